// File: rtl/clus_host_pkg.sv
// Shared types and helpers for the cluster host sequencer.
package clus_host_pkg;

  typedef enum logic [3:0] {
    IDLE, LD_WGHT, LD_IACT, SPAD_LD, WAIT_LD, START, WAIT_COMP, SETTLE, DRAIN
  } state_t;

  localparam int DEF_DATA_BITWIDTH = 16;
  localparam int DEF_ADDR_BITWIDTH = 10;

  function automatic int calc_num_psum(input int kernel_size, input int act_size);
    return (act_size - kernel_size + 1) * (act_size - kernel_size + 1);
  endfunction

endpackage

// File: rtl/clus_host_outbuf.sv
// Two-entry valid/ready FIFO that holds psum words returning from the psum GLB.
module clus_host_outbuf #(
  parameter int DATA_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_BITWIDTH-1:0] push_data,
  input  logic                     pop,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  output logic                     full,
  output logic                     empty,
  output logic [1:0]               count
);

  logic [DATA_BITWIDTH-1:0] mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign out_valid = !empty;
  // Storage is not reset, so the output is forced to zero while nothing is held.
  assign out_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/clus_host_seq.sv
// Host-side sequencer: loads weight/iact GLBs, runs the cluster, streams psums out.
// Optional watchdog on the wait states is enabled by defining CLUS_HOST_TIMEOUT_EN.
module clus_host_seq import clus_host_pkg::*; #(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int NUM_WGHT      = 9,
  parameter int NUM_IACT      = 144,
  parameter int NUM_PSUM      = calc_num_psum(3, 12),
  parameter int PSUM_SETTLE   = 4,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_go,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     write_en_wght,
  output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
  output logic [DATA_BITWIDTH-1:0] w_data_wght,
  output logic                     write_en_iact,
  output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
  output logic [DATA_BITWIDTH-1:0] w_data_iact,
  output logic                     load_spad_ctrl_wght,
  output logic                     load_spad_ctrl_iact,
  output logic                     start,
  input  logic                     load_done,
  input  logic                     compute_done,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     job_done,
  output logic                     err
);

  localparam int AW = ADDR_BITWIDTH;
  localparam logic [AW-1:0] WGHT_LAST   = AW'(NUM_WGHT - 1);
  localparam logic [AW-1:0] IACT_LAST   = AW'(NUM_IACT - 1);
  localparam logic [AW-1:0] PSUM_LAST   = AW'(NUM_PSUM - 1);
  localparam logic [AW-1:0] SETTLE_LAST = AW'(PSUM_SETTLE - 1);

  if (NUM_WGHT < 1 || NUM_WGHT > (1 << AW) || NUM_IACT < 1 || NUM_IACT > (1 << AW) ||
      NUM_PSUM < 1 || NUM_PSUM > (1 << AW) || PSUM_SETTLE < 1 || PSUM_SETTLE > (1 << AW) ||
      TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("clus_host_seq: word counts or settle length exceed the address counter range");
  end

  state_t        state;
  logic [AW-1:0] cnt;
  logic          cd_q;
  logic          rd_fly;
  logic          rd_all;
  logic          pop;
  logic          buf_full;
  logic          buf_empty;
  logic [1:0]    buf_count;

  assign in_ready      = (state == LD_WGHT) || (state == LD_IACT);
  assign write_en_wght = (state == LD_WGHT) && in_valid;
  assign write_en_iact = (state == LD_IACT) && in_valid;
  assign w_addr_wght   = write_en_wght ? cnt : '0;
  assign w_data_wght   = write_en_wght ? in_data : '0;
  assign w_addr_iact   = write_en_iact ? cnt : '0;
  assign w_data_iact   = write_en_iact ? in_data : '0;

  assign load_spad_ctrl_wght = (state == SPAD_LD);
  assign load_spad_ctrl_iact = (state == SPAD_LD);
  assign start               = (state == START);
  assign busy                = (state != IDLE);

  // Reads in flight plus buffered entries never exceed the two buffer slots.
  assign read_req_psum = (state == DRAIN) && !rd_all && !buf_full && !(rd_fly && !buf_empty);
  assign r_addr_psum   = read_req_psum ? cnt : '0;
  assign pop           = out_valid && out_ready;
  assign job_done      = (state == DRAIN) && rd_all && !rd_fly && (buf_count == 2'd1) && pop;

  clus_host_outbuf #(.DATA_BITWIDTH(DATA_BITWIDTH)) u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_fly),
    .push_data (r_data_psum),
    .pop       (pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

`ifdef CLUS_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wdog;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cd_q   <= 1'b0;
      rd_fly <= 1'b0;
      rd_all <= 1'b0;
`ifdef CLUS_HOST_TIMEOUT_EN
      wdog   <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      cd_q   <= compute_done;
      rd_fly <= read_req_psum;
      case (state)
        IDLE: if (job_go) begin
          state  <= LD_WGHT;
          cnt    <= '0;
          rd_all <= 1'b0;
        end
        LD_WGHT: if (in_valid) begin
          if (cnt == WGHT_LAST) begin
            cnt   <= '0;
            state <= LD_IACT;
          end else cnt <= cnt + 1'b1;
        end
        LD_IACT: if (in_valid) begin
          if (cnt == IACT_LAST) begin
            cnt   <= '0;
            state <= SPAD_LD;
          end else cnt <= cnt + 1'b1;
        end
        SPAD_LD: state <= WAIT_LD;
        WAIT_LD: if (load_done) state <= START;
        START:   state <= WAIT_COMP;
        // Only a fresh rising edge counts; a level left high from before is ignored.
        WAIT_COMP: if (compute_done && !cd_q) begin
          state <= SETTLE;
          cnt   <= '0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= DRAIN;
          end else cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          if (read_req_psum) begin
            if (cnt == PSUM_LAST) rd_all <= 1'b1;
            else cnt <= cnt + 1'b1;
          end
          if (job_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CLUS_HOST_TIMEOUT_EN
      if (state == WAIT_LD || state == WAIT_COMP) begin
        wdog <= wdog + 1'b1;
        if (wdog == WD_LAST) begin
          state <= IDLE;
          err_q <= 1'b1;
        end
      end else wdog <= '0;
`endif
    end
  end

endmodule

// File: doc/clus_host_seq.md
Name: clus_host_seq

Overview:
- Initiator-side sequencer for the accelerator cluster top level. It drives that top level's host interface, which a testbench currently drives.
- Accepts weight and activation word streams and writes them into the weight/iact GLBs. It then triggers the SPAD loads, starts the PE cluster and waits for compute completion.
- After completion it reads back every partial sum from the psum GLB. The psums leave on a valid/ready output stream.
- It sits between an upstream DMA/host stream and the cluster.

Parameters:
- DATA_BITWIDTH, 16, GLB word width.
- ADDR_BITWIDTH, 10, GLB address width.
- NUM_WGHT, 9, weight words per job (kernel_size squared).
- NUM_IACT, 144, activation words per job (act_size squared).
- NUM_PSUM, 100, psum words read back per job ((act_size-kernel_size+1) squared).
- PSUM_SETTLE, 4, cycles to wait after compute_done before the first psum read. This lets the psum router finish its GLB writes.
- TIMEOUT_CYC, 4096, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- job_go  in  1  one-cycle pulse that starts a job; ignored unless in IDLE
- in_data  in  DATA_BITWIDTH  input word; weights first, then activations
- in_valid  in  1  in_data valid
- in_ready  out  1  in_data accepted when in_valid && in_ready
- write_en_wght  out  1  weight GLB write strobe
- w_addr_wght  out  ADDR_BITWIDTH  weight GLB write address
- w_data_wght  out  DATA_BITWIDTH  weight GLB write data
- write_en_iact  out  1  iact GLB write strobe
- w_addr_iact  out  ADDR_BITWIDTH  iact GLB write address
- w_data_iact  out  DATA_BITWIDTH  iact GLB write data
- load_spad_ctrl_wght  out  1  one-cycle pulse
- load_spad_ctrl_iact  out  1  one-cycle pulse
- start  out  1  one-cycle pulse to the PE cluster
- load_done  in  1  SPAD load complete (level)
- compute_done  in  1  cluster write_psum_ctrl
- read_req_psum  out  1  psum GLB read strobe
- r_addr_psum  out  ADDR_BITWIDTH  psum GLB read address
- r_data_psum  in  DATA_BITWIDTH  returned one cycle after read_req_psum
- out_data  out  DATA_BITWIDTH  psum word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse when the last psum is accepted downstream
- err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE and all counters clear.
  - Every output is 0, including the addresses and data.
- FSM: IDLE -> LD_WGHT -> LD_IACT -> SPAD_LD -> WAIT_LD -> START -> WAIT_COMP -> SETTLE -> DRAIN -> IDLE.
- IDLE: leaves to LD_WGHT when job_go is sampled high.
- LD_WGHT:
  - in_ready is 1.
  - Each accepted word produces write_en_wght=1 in the same cycle, with w_addr=wcnt and w_data=in_data, combinationally from the handshake.
  - After word NUM_WGHT-1 is accepted, the next state is LD_IACT.
- LD_IACT: same as LD_WGHT on the iact GLB, with NUM_IACT words, then SPAD_LD.
- SPAD_LD: exactly one cycle with both load_spad_ctrl_wght and load_spad_ctrl_iact high, then WAIT_LD.
- WAIT_LD:
  - Waits for load_done high.
  - If load_done is already high on entry, it proceeds in the next cycle.
- START: exactly one cycle with start=1, then WAIT_COMP.
- WAIT_COMP: waits for a rising edge of compute_done. A level that is high on entry does not count.
- SETTLE: counts PSUM_SETTLE cycles, then DRAIN.
- DRAIN:
  - A read is issued with read_req_psum=1 and r_addr_psum=rcnt only when reads in flight plus entries held in the output buffer is less than 2.
  - The returned word is pushed into the 2-entry output buffer on the following cycle.
  - out_valid reflects a non-empty buffer. Data is held stable while out_valid && !out_ready.
  - After NUM_PSUM reads have been issued and the buffer has fully drained, job_done pulses for one cycle and the state returns to IDLE.
- in_ready is 0 outside LD_WGHT and LD_IACT.
- job_go arriving while busy is dropped.
- Counters:
  - Counters are ADDR_BITWIDTH wide.
  - NUM_* greater than 2^ADDR_BITWIDTH is an elaboration error, enforced by an assertion.
- A reset mid-job aborts immediately. No partial-job state survives.

Optional Feature:
- Macro: CLUS_HOST_TIMEOUT_EN.
- With it defined:
  - A watchdog counts cycles spent in WAIT_LD or WAIT_COMP, and clears on entering either state.
  - When it reaches TIMEOUT_CYC: err is set (sticky until reset), the FSM returns to IDLE, and job_done is not pulsed.
- Without it: there is no counter, err is constant 0, and the FSM waits indefinitely.

Decomposition:
- Package clus_host_pkg holds:
  - the state enum state_t (IDLE..DRAIN);
  - localparam default widths;
  - a function that computes NUM_PSUM from kernel_size/act_size.
- Sub-module clus_host_outbuf: 2-entry valid/ready FIFO with full/empty/count outputs, used in DRAIN.

Test Plan:
- Load count: job_go, stream 9+144 words with in_valid always high. Expect write_en_wght at addresses 0..8 and write_en_iact at 0..143 with matching data. Expect exactly one SPAD_LD pulse cycle.
- Bubbled input: in_valid toggling 1010... Expect no write on idle cycles and still exactly 153 writes total.
- Handshake chain: load_done goes high 5 cycles after the SPAD_LD pulse. Expect start one cycle after load_done is seen. Hold compute_done high on entry, then low, then high. Expect only the rising edge to advance.
- Drain with backpressure: NUM_PSUM=100, out_ready random at 50%. Expect 100 outputs matching addresses 0..99 in order, no drops or duplicates, never more than 2 outstanding, and job_done on the last accept.
- Reset in DRAIN at psum 40: expect all outputs 0 and IDLE. A fresh job must then complete normally.
- Timeout (CLUS_HOST_TIMEOUT_EN, TIMEOUT_CYC=64): never assert load_done. Expect err=1 after 64 cycles in WAIT_LD, return to IDLE, and no job_done.
